issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter: MAX_PENDING, default 3, maximum in-flight writes tracked per register (2-bit counter).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: id_valid  input  1  decode holds an instruction; id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-005 SHALL have ports: id_use_rs1, id_use_rs2, id_wr_rd  input  1 each  operand-read and destination-write flags.
REQ-006 SHALL have ports: ex_ready  input  1  execute accepts; wb_valid  input  1, wb_rd  input  5  writeback completion.
REQ-007 SHALL have port: flush  input  1  kill the unissued instruction and drain.
REQ-008 SHALL have ports: id_stall  output  1  combinational hold to decode; issue_valid  output  1, issue_rd  output  5  registered issue.
REQ-009 SHALL have ports: busy_vec  output  32  bit i = counter i nonzero; stall_count  output  16  stall-cycle counter.

Function
REQ-010 SHALL keep one 2-bit pending counter per register 1..31; register 0 never busy, never counted.
REQ-011 SHALL flag hazard when id_valid and (id_use_rs1, rs1!=0, busy[rs1]) or (id_use_rs2, rs2!=0, busy[rs2]) or (id_wr_rd, rd!=0, count[rd]==MAX_PENDING).
REQ-012 SHALL define fire = id_valid & !hazard & ex_ready & state==RUN & !flush.
REQ-013 SHALL drive id_stall = id_valid & !fire, combinationally, same cycle.
REQ-014 SHALL register issue_valid<=fire and issue_rd<=(id_wr_rd ? id_rd : 0) one cycle after fire; issue_rd holds when no fire.
REQ-015 SHALL increment count[id_rd] on fire with id_wr_rd and rd!=0.
REQ-016 SHALL decrement count[wb_rd] on wb_valid with wb_rd!=0 and count>0; wb to zero-count register or x0 ignored.
REQ-017 SHALL leave a counter unchanged when increment and decrement target it in the same cycle.
REQ-018 SHALL implement FSM RUN, STALL, DRAIN: RUN->STALL on id_valid & hazard; STALL->RUN when hazard clears; any->DRAIN on flush; DRAIN->RUN when busy_vec==0 and flush low.
REQ-019 SHALL not issue in STALL-to-RUN transition cycle; issue resumes cycle after entering RUN.
REQ-020 SHALL not clear counters on flush; in-flight writebacks still decrement in DRAIN.
REQ-021 SHALL increment stall_count each cycle in STALL or DRAIN, saturating at 16'hFFFF.
REQ-022 SHALL treat ex_ready low in RUN as stall for id_stall only; no state change, no stall_count increment.

Reset
REQ-023 SHALL on reset clear all counters, busy_vec=0, issue_valid=0, issue_rd=0, stall_count=0, state=RUN.
REQ-024 SHALL give reset priority over flush, fire and wb_valid in the same cycle, including mid-DRAIN.

Configuration
REQ-025 SHALL support macro SCOREBOARD_BYPASS_EN: when defined, a source register with count==1 and wb_valid to it this cycle is not a hazard (same-cycle fire allowed).
REQ-026 SHALL, without SCOREBOARD_BYPASS_EN, evaluate hazard on registered counters only; such fire waits one extra cycle.

Verification
REQ-027 SHALL cover: fire rd=5, next cycle id_use_rs1=1 rs1=5, no wb -> id_stall=1, state STALL, stall_count increments per cycle.
REQ-028 SHALL cover: count[5]=1, wb_valid wb_rd=5 while rs1=5 waits -> bypass build fires same cycle; non-bypass build fires next RUN cycle.
REQ-029 SHALL cover: three fires rd=7 without wb -> count[7]=3; fourth write to rd=7 stalls until a wb_rd=7.
REQ-030 SHALL cover: fire rd=9 and wb_rd=9 same cycle with count[9]=1 -> count[9] stays 1, busy_vec[9]=1.
REQ-031 SHALL cover: flush with count[3]=2 -> DRAIN, no issue; two wb_rd=3 -> busy_vec=0, RUN next cycle.
REQ-032 SHALL cover: reset asserted in DRAIN with busy_vec=32'h0000_0008 -> next cycle all outputs 0, state RUN.

Source files
------------

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register pending-write scoreboard gating in-order issue; `define SCOREBOARD_BYPASS_EN to let a same-cycle writeback clear a source hazard
module issue_scoreboard #(
  parameter int MAX_PENDING = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_wr_rd,
  input  logic        ex_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        id_stall,
  output logic        issue_valid,
  output logic [4:0]  issue_rd,
  output logic [31:0] busy_vec,
  output logic [15:0] stall_count
);
  typedef enum logic [1:0] {RUN, STALL, DRAIN} state_t;
  localparam logic [1:0] MAXP = 2'(MAX_PENDING);
  state_t      state_q;
  logic [1:0]  cnt_q [32];
  logic [1:0]  cnt_d [32];
  logic [31:0] busy, inc_vec, dec_vec;
  logic        src1_busy, src2_busy, rd_full, hazard, fire;
  logic        issue_valid_q;
  logic [4:0]  issue_rd_q;
  logic [15:0] stall_count_q;
  // x0 is never tracked, so its busy bit is tied low
  always_comb begin
    busy = '0;
    for (int i = 1; i < 32; i++) busy[i] = cnt_q[i] != 2'd0;
  end
`ifdef SCOREBOARD_BYPASS_EN
  assign src1_busy = busy[id_rs1] & ~(wb_valid & wb_rd == id_rs1 & cnt_q[id_rs1] == 2'd1);
  assign src2_busy = busy[id_rs2] & ~(wb_valid & wb_rd == id_rs2 & cnt_q[id_rs2] == 2'd1);
`else
  assign src1_busy = busy[id_rs1];
  assign src2_busy = busy[id_rs2];
`endif
  assign rd_full = id_rd != 5'd0 && cnt_q[id_rd] == MAXP;
  assign hazard = id_valid & ((id_use_rs1 & id_rs1 != 5'd0 & src1_busy) |
                              (id_use_rs2 & id_rs2 != 5'd0 & src2_busy) |
                              (id_wr_rd & rd_full));
  assign fire = id_valid & ~hazard & ex_ready & state_q == RUN & ~flush;
  assign id_stall = id_valid & ~fire;
  assign inc_vec = (fire & id_wr_rd & id_rd != 5'd0) ? 32'd1 << id_rd : 32'd0;
  assign dec_vec = (wb_valid & wb_rd != 5'd0) ? (32'd1 << wb_rd) & busy : 32'd0;
  // a simultaneous increment and decrement of one register cancel out
  always_comb begin
    for (int i = 0; i < 32; i++)
      cnt_d[i] = (inc_vec[i] & ~dec_vec[i]) ? cnt_q[i] + 2'd1 :
                 (dec_vec[i] & ~inc_vec[i]) ? cnt_q[i] - 2'd1 : cnt_q[i];
  end
  // pending-write counters; flush leaves them so in-flight writebacks still retire
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '{default: 2'd0};
    else cnt_q <= cnt_d;
  end
  // issue FSM with registered issue outputs and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      issue_valid_q <= 1'b0;
      issue_rd_q    <= 5'd0;
      stall_count_q <= 16'd0;
    end else begin
      issue_valid_q <= fire;
      if (fire) issue_rd_q <= id_wr_rd ? id_rd : 5'd0;
      if (state_q != RUN && stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 16'd1;
      state_q <= flush ? DRAIN :
                 state_q != DRAIN ? (hazard ? STALL : RUN) :
                 busy == 32'd0 ? RUN : DRAIN;
    end
  end
  assign issue_valid = issue_valid_q;
  assign issue_rd    = issue_rd_q;
  assign busy_vec    = busy;
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed vector table plus hand sequences for the default (non-bypass) build
module tb_issue_scoreboard;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_wr_rd = 0, ex_ready = 0, wb_valid = 0, flush = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0, wb_rd = 0;
  logic id_stall, issue_valid;
  logic [4:0] issue_rd;
  logic [31:0] busy_vec;
  logic [15:0] stall_count;
  int total = 0, bad = 0;
  typedef struct {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2; logic [4:0] rd; logic wr;
    logic ex; logic wbv; logic [4:0] wbr; logic fl;
    logic e_stall; logic e_iv; logic [4:0] e_rd; logic [31:0] e_busy; logic [15:0] e_sc;
  } vec_t;
  vec_t tv[$];
  issue_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr_rd(id_wr_rd), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .id_stall(id_stall), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .busy_vec(busy_vec), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic wr, logic ex, logic wbv, logic [4:0] wbr, logic fl,
                              logic st, logic iv, logic [4:0] ird, logic [31:0] bz, logic [15:0] sc);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.wr = wr;
    t.ex = ex; t.wbv = wbv; t.wbr = wbr; t.fl = fl;
    t.e_stall = st; t.e_iv = iv; t.e_rd = ird; t.e_busy = bz; t.e_sc = sc;
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_use_rs1 = t.u1; id_rs2 = t.rs2; id_use_rs2 = t.u2;
    id_rd = t.rd; id_wr_rd = t.wr; ex_ready = t.ex; wb_valid = t.wbv; wb_rd = t.wbr; flush = t.fl;
  endtask
  task automatic post(string tag, logic iv, logic [4:0] ird, logic [31:0] bz, logic [15:0] sc);
    chk({tag, " issue_valid"}, 32'(issue_valid), 32'(iv));
    chk({tag, " issue_rd"}, 32'(issue_rd), 32'(ird));
    chk({tag, " busy_vec"}, busy_vec, bz);
    chk({tag, " stall_count"}, 32'(stall_count), 32'(sc));
  endtask
  initial begin
    // fire rd5, then dependent reader stalls; writeback retires, STALL->RUN cycle, then issue
    tv.push_back(mk(1,0,0,0,0,5,1,1,0,0,0, 0,1,5,32'h20,0));
    tv.push_back(mk(1,5,1,0,0,0,0,1,0,0,0, 1,0,5,32'h20,0));
    tv.push_back(mk(1,5,1,0,0,0,0,1,0,0,0, 1,0,5,32'h20,1));
    tv.push_back(mk(1,0,0,5,1,0,0,1,0,0,0, 1,0,5,32'h20,2));
    tv.push_back(mk(1,5,1,0,0,0,0,1,1,5,0, 1,0,5,32'h0,3));
    tv.push_back(mk(1,5,1,0,0,0,0,1,0,0,0, 1,0,5,32'h0,4));
    tv.push_back(mk(1,5,1,0,0,0,0,1,0,0,0, 0,1,0,32'h0,4));
    // ex_ready low: stall only
    tv.push_back(mk(1,0,0,0,0,2,1,0,0,0,0, 1,0,0,32'h0,4));
    // simultaneous inc/dec on rd9, then single wb empties it; stray wbs ignored
    tv.push_back(mk(1,0,0,0,0,9,1,1,0,0,0, 0,1,9,32'h200,4));
    tv.push_back(mk(1,0,0,0,0,9,1,1,1,9,0, 0,1,9,32'h200,4));
    tv.push_back(mk(0,0,0,0,0,0,0,1,1,9,0, 0,0,9,32'h0,4));
    tv.push_back(mk(0,0,0,0,0,0,0,1,1,4,0, 0,0,9,32'h0,4));
    tv.push_back(mk(0,0,0,0,0,0,0,1,1,0,0, 0,0,9,32'h0,4));
    tv.push_back(mk(1,0,0,0,0,0,1,1,0,0,0, 0,1,0,32'h0,4));
    // three writes to rd7 fill it; fourth stalls until a wb
    tv.push_back(mk(1,0,0,0,0,7,1,1,0,0,0, 0,1,7,32'h80,4));
    tv.push_back(mk(1,0,0,0,0,7,1,1,0,0,0, 0,1,7,32'h80,4));
    tv.push_back(mk(1,0,0,0,0,7,1,1,0,0,0, 0,1,7,32'h80,4));
    tv.push_back(mk(1,0,0,0,0,7,1,1,0,0,0, 1,0,7,32'h80,4));
    tv.push_back(mk(1,0,0,0,0,7,1,1,1,7,0, 1,0,7,32'h80,5));
    tv.push_back(mk(1,0,0,0,0,7,1,1,0,0,0, 1,0,7,32'h80,6));
    tv.push_back(mk(1,0,0,0,0,7,1,1,0,0,0, 0,1,7,32'h80,6));
    tv.push_back(mk(0,0,0,0,0,0,0,1,1,7,0, 0,0,7,32'h80,6));
    tv.push_back(mk(0,0,0,0,0,0,0,1,1,7,0, 0,0,7,32'h80,6));
    tv.push_back(mk(0,0,0,0,0,0,0,1,1,7,0, 0,0,7,32'h0,6));
    // count[3]=2, flush -> DRAIN, two wbs drain it, then RUN
    tv.push_back(mk(1,0,0,0,0,3,1,1,0,0,0, 0,1,3,32'h8,6));
    tv.push_back(mk(1,0,0,0,0,3,1,1,0,0,0, 0,1,3,32'h8,6));
    tv.push_back(mk(1,0,0,0,0,1,1,1,0,0,1, 1,0,3,32'h8,6));
    tv.push_back(mk(1,0,0,0,0,1,1,1,1,3,0, 1,0,3,32'h8,7));
    tv.push_back(mk(1,0,0,0,0,1,1,1,1,3,0, 1,0,3,32'h0,8));
    tv.push_back(mk(1,0,0,0,0,1,1,1,0,0,0, 1,0,3,32'h0,9));
    tv.push_back(mk(1,0,0,0,0,1,1,1,0,0,0, 0,1,1,32'h2,9));
    tv.push_back(mk(0,0,0,0,0,0,0,1,1,1,0, 0,0,1,32'h0,9));
    repeat (2) @(posedge clk);
    #1;
    post("reset", 0, 0, 0, 0);
    chk("reset id_stall", 32'(id_stall), 0);
    reset = 0;
    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d id_stall", i), 32'(id_stall), 32'(tv[i].e_stall));
      @(posedge clk);
      #1;
      post($sformatf("v%0d", i), tv[i].e_iv, tv[i].e_rd, tv[i].e_busy, tv[i].e_sc);
    end
    // reset in DRAIN with busy_vec=8 beats flush, wb and issue
    drive(mk(1,0,0,0,0,3,1,1,0,0,0, 0,0,0,0,0));
    @(posedge clk); #1;
    post("d_fire", 1, 3, 32'h8, 9);
    drive(mk(0,0,0,0,0,0,0,1,0,0,1, 0,0,0,0,0));
    @(posedge clk); #1;
    drive(mk(0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0));
    @(posedge clk); #1;
    post("d_drain", 0, 3, 32'h8, 10);
    drive(mk(1,0,0,0,0,4,1,1,1,3,1, 0,0,0,0,0));
    reset = 1;
    @(posedge clk); #1;
    post("d_reset", 0, 0, 0, 0);
    reset = 0;
    drive(mk(1,0,0,0,0,4,1,1,0,0,0, 0,0,0,0,0));
    #1;
    chk("d_run id_stall", 32'(id_stall), 0);
    @(posedge clk); #1;
    post("d_run", 1, 4, 32'h10, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
